bcd_pipe_addsub: RTL and testbench
==================================

# bcd_pipe_addsub

Parametrised, pipelined N-digit BCD adder/subtractor with a valid/ready handshake. It replaces the fixed 3-digit registered adder wherever operands are wider than 12 bits or a result stream needs back-pressure. The digit carry chain is split across pipeline stages, so clock rate is independent of DIGITS. Subtraction uses nine's complement. Inputs containing a non-BCD digit are flagged.

## Interface
- DIGITS, 4: number of BCD digits per operand; must be at least 1.
- DIGITS_PER_STAGE, 1: digits resolved per pipeline stage; DIGITS must be an exact multiple of this value.
- NSTG: derived as DIGITS/DIGITS_PER_STAGE; not overridable.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  4*DIGITS  BCD operand A; digit 0 is in bits [3:0].
- b  in  4*DIGITS  BCD operand B.
- cin  in  1  carry-in. Used unchanged in both modes.
- mode  in  1  0 selects A+B+cin; 1 selects A+nines(B)+cin.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result.
- s  out  4*DIGITS  BCD sum or difference.
- cout  out  1  decimal carry-out. In subtract mode with cin=1, cout=1 means A≥B (no borrow).
- err  out  1  at least one digit of a or b was greater than 9.

## Operation
- A beat is accepted on a rising edge with in_valid && in_ready. A result is consumed on an edge with out_valid && out_ready.
- Pipeline structure:
  - An input register captures a, b (nine's-complemented per digit when mode=1), cin, and the err flag.
  - NSTG stage registers follow.
  - Stage k resolves digit group k and forwards its carry to stage k+1.
  - Already-resolved lower digits and not-yet-resolved upper operand digits travel alongside the data in skew registers.
- Per-digit rule: t = a_d + b_d + c, computed 5 bits wide.
  - If t > 9: digit = t + 6, keeping only the low 4 bits; carry = 1.
  - Otherwise: digit = t; carry = 0.
- cout is the carry out of digit DIGITS-1.
- err: any digit of a or b > 9 at acceptance gives err=1 and forces s=0 and cout=0 for that beat. The beat still occupies the pipeline and must be consumed.
- Stall rule: the whole pipeline freezes when out_valid && !out_ready.
  - in_ready = out_ready || !out_valid.
  - No beat is dropped or duplicated.
  - Bubbles propagate; they are not compacted.
- Stage valid bits track occupancy. Data registers are loaded only when the corresponding stage advances.

## Timing
- Reset (rst low, asynchronous): every valid bit clears; s=0, cout=0, err=0, out_valid=0. in_ready=1 combinationally once rst is released.
- Latency without stalls: out_valid rises NSTG+1 edges after the acceptance edge, counting the acceptance edge as 1. With the defaults this is 5 edges.
- Throughput is one beat per cycle while out_ready=1.
- While out_valid=1 and out_ready=0, s, cout and err hold stable.
- Simultaneous accept and consume on a full pipeline is legal. In that case occupancy is unchanged.
- Reset asserted mid-operation discards all in-flight beats immediately. No partial result appears after reset is released.
- in_ready has a combinational path from out_ready. No other output is combinational.

## Structure
- The shared package bcd_pkg holds:
  - the BCD digit width constant (4) and digit type;
  - the constant 9;
  - a nines-complement function for one digit;
  - an is_bcd(digit) function.
- Sub-module bcd_digit_add: a combinational 1-digit adder with correction; inputs a_d, b_d, c; outputs s_d, c_out.
  - Each stage instantiates DIGITS_PER_STAGE copies of it, chained.
- The pipeline itself is generate loops over NSTG with a valid-bit shift chain. No explicit FSM beyond the per-stage valid bits.

## Test plan
- Carry ripple across all stages: defaults, mode=0, a=9999, b=0001, cin=0 → s=0000, cout=1, err=0; out_valid on the 5th edge.
- Subtraction, no borrow: mode=1, a=0123, b=0045, cin=1 → s=0078, cout=1.
- Subtraction with borrow: mode=1, a=0045, b=0123, cin=1 → s=9922, cout=0.
- Back-to-back stream with stall:
  - Stream 1+1, 2+2, … 8+8 (all with cin=0, mode=0) on consecutive cycles; hold out_ready=0 for 3 cycles mid-stream.
  - Required: results 0002, 0004, … 0016 in order, with none lost or repeated; s holds stable during the stall; in_ready=0 only while out_valid && !out_ready.
- Invalid digit: a=00A3, b=0001, mode=0, cin=0 → err=1, s=0000, cout=0. The following valid beat 0005+0005 still gives s=0010, cout=0, err=0.
- Reset mid-flight: accept 3 beats, assert rst low for one cycle → out_valid=0, s=0 immediately. After release, no stale result appears and a new beat 0001+0001 returns s=0002 after 5 edges.
- Repeat the carry-ripple and stream scenarios with DIGITS=6, DIGITS_PER_STAGE=2 (latency 4):
  - carry ripple: a=999999, b=000001, cin=0, mode=0 → s=000000, cout=1;
  - stream: the same 1+1 … 8+8 sequence gives 000002 … 000016.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD digit definitions and per-digit helpers.
package bcd_pkg;

  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_NINE = 4'd9;

  function automatic bcd_digit_t nines(input bcd_digit_t d);
    return BCD_NINE - d;
  endfunction

  function automatic logic is_bcd(input bcd_digit_t d);
    return d <= BCD_NINE;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD adder with decimal correction; purely combinational.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t a_d,
  input  bcd_digit_t b_d,
  input  logic       c,
  output bcd_digit_t s_d,
  output logic       c_out
);

  logic [4:0] t;

  always_comb begin
    t = {1'b0, a_d} + {1'b0, b_d} + {4'b0000, c};
    if (t > 5'd9) begin
      s_d   = t[3:0] + 4'd6;
      c_out = 1'b1;
    end else begin
      s_d   = t[3:0];
      c_out = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_pipe_addsub.sv
// Pipelined N-digit BCD adder/subtractor with valid/ready handshake.
// One digit group is resolved per stage; operands shrink and the sum grows as a beat moves down.
module bcd_pipe_addsub
  import bcd_pkg::*;
#(
  parameter int DIGITS           = 4,
  parameter int DIGITS_PER_STAGE = 1
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  input  logic                  mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   s,
  output logic                  cout,
  output logic                  err
);

  localparam int NSTG = DIGITS / DIGITS_PER_STAGE;
  localparam int W    = BCD_W * DIGITS;
  localparam int GW   = BCD_W * DIGITS_PER_STAGE;

  logic         adv;
  logic         bad;
  logic [W-1:0] b_eff;
  logic [W-1:0] a_in_q, b_in_q;
  logic         c_in_q, err_in_q, vld_in_q;

  // The whole pipe advances together unless the output is blocked.
  assign in_ready = out_ready || !out_valid;
  assign adv      = in_ready;

  always_comb begin
    bad   = 1'b0;
    b_eff = '0;
    for (int d = 0; d < DIGITS; d++) begin
      bad = bad | !is_bcd(a[d*BCD_W +: BCD_W]) | !is_bcd(b[d*BCD_W +: BCD_W]);
      b_eff[d*BCD_W +: BCD_W] = mode ? nines(b[d*BCD_W +: BCD_W]) : b[d*BCD_W +: BCD_W];
    end
  end

  // A flagged beat carries zero operands and carry, so it emerges as s=0, cout=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_in_q <= 1'b0;
      a_in_q   <= '0;
      b_in_q   <= '0;
      c_in_q   <= 1'b0;
      err_in_q <= 1'b0;
    end else if (adv) begin
      vld_in_q <= in_valid;
      if (in_valid) begin
        a_in_q   <= bad ? '0 : a;
        b_in_q   <= bad ? '0 : b_eff;
        c_in_q   <= cin & ~bad;
        err_in_q <= bad;
      end
    end
  end

  for (genvar k = 0; k < NSTG; k++) begin : stg
    localparam int OW = W - k * GW;

    logic [OW-1:0]         a_i, b_i;
    logic                  c_i, e_i, v_i;
    logic [DIGITS_PER_STAGE:0] cc;
    logic [GW-1:0]         grp;
    logic [(k+1)*GW-1:0]   sum_d, sum_q;
    logic                  c_q, e_q, v_q;

    if (k == 0) begin : g_src
      assign a_i   = a_in_q;
      assign b_i   = b_in_q;
      assign c_i   = c_in_q;
      assign e_i   = err_in_q;
      assign v_i   = vld_in_q;
      assign sum_d = grp;
    end else begin : g_src
      assign a_i   = stg[k-1].g_ops.a_q;
      assign b_i   = stg[k-1].g_ops.b_q;
      assign c_i   = stg[k-1].c_q;
      assign e_i   = stg[k-1].e_q;
      assign v_i   = stg[k-1].v_q;
      assign sum_d = {grp, stg[k-1].sum_q};
    end

    assign cc[0] = c_i;
    for (genvar d = 0; d < DIGITS_PER_STAGE; d++) begin : g_dig
      bcd_digit_add u_add (
        .a_d   (a_i[d*BCD_W +: BCD_W]),
        .b_d   (b_i[d*BCD_W +: BCD_W]),
        .c     (cc[d]),
        .s_d   (grp[d*BCD_W +: BCD_W]),
        .c_out (cc[d+1])
      );
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        v_q   <= 1'b0;
        sum_q <= '0;
        c_q   <= 1'b0;
        e_q   <= 1'b0;
      end else if (adv) begin
        v_q <= v_i;
        if (v_i) begin
          sum_q <= sum_d;
          c_q   <= cc[DIGITS_PER_STAGE];
          e_q   <= e_i;
        end
      end
    end

    // Unresolved upper operand digits ride along to the next stage.
    if (k < NSTG - 1) begin : g_ops
      logic [OW-GW-1:0] a_q, b_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv && v_i) begin
          a_q <= a_i[OW-1:GW];
          b_q <= b_i[OW-1:GW];
        end
      end
    end
  end

  assign s         = stg[NSTG-1].sum_q;
  assign cout      = stg[NSTG-1].c_q;
  assign err       = stg[NSTG-1].e_q;
  assign out_valid = stg[NSTG-1].v_q;

endmodule

// File: tb/tb_bcd_pipe_addsub.sv
// Directed bench for bcd_pipe_addsub at default size and at 6 digits / 2 per stage.
module tb_bcd_pipe_addsub;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        in_valid0, in_ready0, cin0, mode0, out_valid0, out_ready0, cout0, err0;
  logic [15:0] a0, b0, s0;
  logic        in_valid1, in_ready1, cin1, mode1, out_valid1, out_ready1, cout1, err1;
  logic [23:0] a1, b1, s1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  bcd_pipe_addsub dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .b(b0), .cin(cin0), .mode(mode0),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .s(s0), .cout(cout0), .err(err0)
  );

  bcd_pipe_addsub #(.DIGITS(6), .DIGITS_PER_STAGE(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .mode(mode1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .s(s1), .cout(cout1), .err(err1)
  );

  // Drives one beat into an empty dut0 and waits (bounded) for its result.
  task automatic send0(input logic [15:0] av, input logic [15:0] bv, input logic m, input logic c,
                       output int lat, output logic [15:0] so, output logic co, output logic eo);
    a0 = av; b0 = bv; mode0 = m; cin0 = c; in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    lat = 1;
    while (!out_valid0 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    so = s0; co = cout0; eo = err0;
    @(posedge clk); #1;
  endtask

  task automatic send1(input logic [23:0] av, input logic [23:0] bv, input logic m, input logic c,
                       output int lat, output logic [23:0] so, output logic co, output logic eo);
    a1 = av; b1 = bv; mode1 = m; cin1 = c; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    lat = 1;
    while (!out_valid1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    so = s1; co = cout1; eo = err1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #3;
    n_total++; if (out_valid0 !== 1'b0) $display("FAIL reset_out_valid0: got %b expected 0", out_valid0); else n_pass++;
    n_total++; if (s0 !== 16'h0000) $display("FAIL reset_s0: got %h expected 0000", s0); else n_pass++;
    n_total++; if (cout0 !== 1'b0) $display("FAIL reset_cout0: got %b expected 0", cout0); else n_pass++;
    n_total++; if (err0 !== 1'b0) $display("FAIL reset_err0: got %b expected 0", err0); else n_pass++;
    n_total++; if (out_valid1 !== 1'b0) $display("FAIL reset_out_valid1: got %b expected 0", out_valid1); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_total++; if (in_ready0 !== 1'b1) $display("FAIL reset_in_ready0: got %b expected 1", in_ready0); else n_pass++;
    n_total++; if (in_ready1 !== 1'b1) $display("FAIL reset_in_ready1: got %b expected 1", in_ready1); else n_pass++;
  endtask

  task automatic test_carry4();
    int lat; logic [15:0] so; logic co, eo;
    send0(16'h9999, 16'h0001, 1'b0, 1'b0, lat, so, co, eo);
    n_total++; if (so !== 16'h0000) $display("FAIL carry4_s: got %h expected 0000", so); else n_pass++;
    n_total++; if (co !== 1'b1) $display("FAIL carry4_cout: got %b expected 1", co); else n_pass++;
    n_total++; if (eo !== 1'b0) $display("FAIL carry4_err: got %b expected 0", eo); else n_pass++;
    n_total++; if (lat !== 5) $display("FAIL carry4_latency: got %0d expected 5", lat); else n_pass++;
  endtask

  task automatic test_subtract();
    int lat; logic [15:0] so; logic co, eo;
    send0(16'h0123, 16'h0045, 1'b1, 1'b1, lat, so, co, eo);
    n_total++; if (so !== 16'h0078) $display("FAIL sub_noborrow_s: got %h expected 0078", so); else n_pass++;
    n_total++; if (co !== 1'b1) $display("FAIL sub_noborrow_cout: got %b expected 1", co); else n_pass++;
    send0(16'h0045, 16'h0123, 1'b1, 1'b1, lat, so, co, eo);
    n_total++; if (so !== 16'h9922) $display("FAIL sub_borrow_s: got %h expected 9922", so); else n_pass++;
    n_total++; if (co !== 1'b0) $display("FAIL sub_borrow_cout: got %b expected 0", co); else n_pass++;
    n_total++; if (eo !== 1'b0) $display("FAIL sub_borrow_err: got %b expected 0", eo); else n_pass++;
  endtask

  task automatic test_back_to_back4();
    logic [15:0] exp_q [8] = '{16'h0002, 16'h0004, 16'h0006, 16'h0008,
                               16'h0010, 16'h0012, 16'h0014, 16'h0016};
    int idx = 0, got = 0, extra = 0;
    logic [15:0] held = '0;
    logic stall_seen = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready0 = !(cyc >= 6 && cyc < 9);
      in_valid0  = (idx < 8);
      a0 = 16'(idx + 1); b0 = 16'(idx + 1); mode0 = 1'b0; cin0 = 1'b0;
      #1;
      n_total++;
      if (in_ready0 !== (out_ready0 || !out_valid0))
        $display("FAIL stream4_in_ready cyc%0d: got %b expected %b", cyc, in_ready0, out_ready0 || !out_valid0);
      else n_pass++;
      if (out_valid0 && out_ready0) begin
        if (got < 8) begin
          n_total++;
          if (s0 !== exp_q[got]) $display("FAIL stream4_s[%0d]: got %h expected %h", got, s0, exp_q[got]);
          else n_pass++;
          got++;
        end else extra++;
      end
      if (out_valid0 && !out_ready0) begin
        if (stall_seen) begin
          n_total++;
          if (s0 !== held) $display("FAIL stream4_hold: got %h expected %h", s0, held); else n_pass++;
        end
        held = s0;
        stall_seen = 1'b1;
      end
      if (in_valid0 && in_ready0) idx++;
      @(posedge clk); #1;
    end
    in_valid0 = 1'b0; out_ready0 = 1'b1;
    n_total++; if (got !== 8) $display("FAIL stream4_count: got %0d expected 8", got); else n_pass++;
    n_total++; if (extra !== 0) $display("FAIL stream4_extra: got %0d expected 0", extra); else n_pass++;
    n_total++; if (stall_seen !== 1'b1) $display("FAIL stream4_stall: got %b expected 1", stall_seen); else n_pass++;
  endtask

  task automatic test_invalid_digit();
    int lat; logic [15:0] so; logic co, eo;
    send0(16'h00A3, 16'h0001, 1'b0, 1'b0, lat, so, co, eo);
    n_total++; if (eo !== 1'b1) $display("FAIL invalid_err: got %b expected 1", eo); else n_pass++;
    n_total++; if (so !== 16'h0000) $display("FAIL invalid_s: got %h expected 0000", so); else n_pass++;
    n_total++; if (co !== 1'b0) $display("FAIL invalid_cout: got %b expected 0", co); else n_pass++;
    send0(16'h0005, 16'h0005, 1'b0, 1'b0, lat, so, co, eo);
    n_total++; if (so !== 16'h0010) $display("FAIL after_invalid_s: got %h expected 0010", so); else n_pass++;
    n_total++; if (co !== 1'b0) $display("FAIL after_invalid_cout: got %b expected 0", co); else n_pass++;
    n_total++; if (eo !== 1'b0) $display("FAIL after_invalid_err: got %b expected 0", eo); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    int lat, stale = 0; logic [15:0] so; logic co, eo;
    for (int i = 0; i < 3; i++) begin
      a0 = 16'(i + 1); b0 = 16'(i + 1); mode0 = 1'b0; cin0 = 1'b0; in_valid0 = 1'b1;
      @(posedge clk); #1;
    end
    in_valid0 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_total++; if (out_valid0 !== 1'b1) $display("FAIL midrst_pre_valid: got %b expected 1", out_valid0); else n_pass++;
    n_total++; if (s0 !== 16'h0002) $display("FAIL midrst_pre_s: got %h expected 0002", s0); else n_pass++;
    rst = 1'b0;
    #1;
    n_total++; if (out_valid0 !== 1'b0) $display("FAIL midrst_valid: got %b expected 0", out_valid0); else n_pass++;
    n_total++; if (s0 !== 16'h0000) $display("FAIL midrst_s: got %h expected 0000", s0); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_total++; if (in_ready0 !== 1'b1) $display("FAIL midrst_in_ready: got %b expected 1", in_ready0); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid0) stale++;
    end
    n_total++; if (stale !== 0) $display("FAIL midrst_stale: got %0d expected 0", stale); else n_pass++;
    send0(16'h0001, 16'h0001, 1'b0, 1'b0, lat, so, co, eo);
    n_total++; if (so !== 16'h0002) $display("FAIL midrst_new_s: got %h expected 0002", so); else n_pass++;
    n_total++; if (lat !== 5) $display("FAIL midrst_new_latency: got %0d expected 5", lat); else n_pass++;
  endtask

  task automatic test_carry6();
    int lat; logic [23:0] so; logic co, eo;
    send1(24'h999999, 24'h000001, 1'b0, 1'b0, lat, so, co, eo);
    n_total++; if (so !== 24'h000000) $display("FAIL carry6_s: got %h expected 000000", so); else n_pass++;
    n_total++; if (co !== 1'b1) $display("FAIL carry6_cout: got %b expected 1", co); else n_pass++;
    n_total++; if (eo !== 1'b0) $display("FAIL carry6_err: got %b expected 0", eo); else n_pass++;
    n_total++; if (lat !== 4) $display("FAIL carry6_latency: got %0d expected 4", lat); else n_pass++;
  endtask

  task automatic test_back_to_back6();
    logic [23:0] exp_q [8] = '{24'h000002, 24'h000004, 24'h000006, 24'h000008,
                               24'h000010, 24'h000012, 24'h000014, 24'h000016};
    int idx = 0, got = 0, extra = 0;
    logic [23:0] held = '0;
    logic stall_seen = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready1 = !(cyc >= 5 && cyc < 8);
      in_valid1  = (idx < 8);
      a1 = 24'(idx + 1); b1 = 24'(idx + 1); mode1 = 1'b0; cin1 = 1'b0;
      #1;
      n_total++;
      if (in_ready1 !== (out_ready1 || !out_valid1))
        $display("FAIL stream6_in_ready cyc%0d: got %b expected %b", cyc, in_ready1, out_ready1 || !out_valid1);
      else n_pass++;
      if (out_valid1 && out_ready1) begin
        if (got < 8) begin
          n_total++;
          if (s1 !== exp_q[got]) $display("FAIL stream6_s[%0d]: got %h expected %h", got, s1, exp_q[got]);
          else n_pass++;
          got++;
        end else extra++;
      end
      if (out_valid1 && !out_ready1) begin
        if (stall_seen) begin
          n_total++;
          if (s1 !== held) $display("FAIL stream6_hold: got %h expected %h", s1, held); else n_pass++;
        end
        held = s1;
        stall_seen = 1'b1;
      end
      if (in_valid1 && in_ready1) idx++;
      @(posedge clk); #1;
    end
    in_valid1 = 1'b0; out_ready1 = 1'b1;
    n_total++; if (got !== 8) $display("FAIL stream6_count: got %0d expected 8", got); else n_pass++;
    n_total++; if (extra !== 0) $display("FAIL stream6_extra: got %0d expected 0", extra); else n_pass++;
    n_total++; if (stall_seen !== 1'b1) $display("FAIL stream6_stall: got %b expected 1", stall_seen); else n_pass++;
  endtask

  initial begin
    in_valid0 = 1'b0; a0 = '0; b0 = '0; cin0 = 1'b0; mode0 = 1'b0; out_ready0 = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; mode1 = 1'b0; out_ready1 = 1'b1;
    test_reset();
    test_carry4();
    test_subtract();
    test_back_to_back4();
    test_invalid_digit();
    test_reset_midflight();
    test_carry6();
    test_back_to_back6();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
